// File: rtl/floating_point_unit_pkg.sv
// Shared FPU types and constants used by the adder back-end and the rounder.
package floating_point_unit_pkg;

    localparam logic [7:0] MAX_EXP = 8'hFF;

    // IEEE-754 binary32 layout
    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float32_t;

    // Bits shifted out below the LSB of the unrounded significand
    typedef struct packed {
        logic guard;
        logic round;
        logic sticky;
    } round_bits_t;

    // RISC-V frm encoding; 101-111 are reserved and handled as RNE
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rounding_mode_t;

    // fflags ordering {NV, DZ, OF, UF, NX}
    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    localparam float32_t    CANONICAL_NAN  = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG        = 31'h7F80_0000;
    localparam logic [30:0] MAX_FINITE_MAG = 31'h7F7F_FFFF;

endpackage

// File: rtl/floating_point_rounder.sv
// Two-stage elastic float32 rounder sitting behind the adder.
// S1 registers the round-up decision and the incremented 24-bit significand;
// S2 (output register) resolves carry-out, overflow saturation and flags.
// Optional macro FPU_ROUND_MODES_EN: when defined all five rounding modes are
// honoured; otherwise round_mode_i is ignored and RNE is always used.
module floating_point_rounder
    import floating_point_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  float32_t    operand_i,
    input  round_bits_t round_bits_i,
    input  logic        invalid_i,
    input  logic        overflow_i,
    input  logic        underflow_i,
    input  logic [2:0]  round_mode_i,
    output logic        valid_o,
    input  logic        ready_i,
    output float32_t    result_o,
    output fflags_t     flags_o,
    input  logic        clear_flags_i,
    output fflags_t     acc_flags_o
);

    // Round-up decision for a single operand
    function automatic logic round_up(input rounding_mode_t mode, input logic sign,
                                      input logic lsb, input round_bits_t rb);
        logic inexact;
        logic up;
        inexact = rb.guard | rb.round | rb.sticky;
        case (mode)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & inexact;
            RM_RUP:  up = !sign & inexact;
            RM_RMM:  up = rb.guard;
            default: up = rb.guard & (rb.round | rb.sticky | lsb);
        endcase
        return up;
    endfunction

    // Magnitude returned on overflow: infinity or the largest finite value
    function automatic logic [30:0] sat_mag(input rounding_mode_t mode, input logic sign);
        logic [30:0] mag;
        case (mode)
            RM_RTZ:  mag = MAX_FINITE_MAG;
            RM_RDN:  mag = sign ? INF_MAG : MAX_FINITE_MAG;
            RM_RUP:  mag = sign ? MAX_FINITE_MAG : INF_MAG;
            default: mag = INF_MAG;
        endcase
        return mag;
    endfunction

    rounding_mode_t mode_eff;

`ifdef FPU_ROUND_MODES_EN
    assign mode_eff = rounding_mode_t'(round_mode_i);
`else
    logic unused_round_mode;
    assign unused_round_mode = ^round_mode_i;
    assign mode_eff          = RM_RNE;
`endif

    // Handshake / stage control
    logic           s1_valid;
    logic           s1_adv;
    logic           s2_adv;
    logic           out_hs;

    // S1 registers
    float32_t       s1_op;
    logic [24:0]    s1_sum;
    rounding_mode_t s1_mode;
    logic           s1_inexact;
    logic           s1_ovf_in;
    logic           s1_unf_in;
    logic           s1_nv;

    // S1 combinational datapath
    logic [23:0]    sig_in;
    logic           up_in;
    logic [24:0]    sig_sum;

    // S2 combinational datapath
    logic [7:0]     s2_exp;
    logic [22:0]    s2_mant;
    logic           s2_ovf;
    logic           s2_nx;
    logic           s2_inf;
    float32_t       s2_result;
    fflags_t        s2_flags;

    assign s2_adv  = !valid_o | ready_i;
    assign s1_adv  = s1_valid & s2_adv;
    assign ready_o = !s1_valid | s1_adv;
    assign out_hs  = valid_o & ready_i;

    // S1: hidden bit follows the exponent so denormals increment correctly
    always_comb begin
        sig_in  = {operand_i.exponent != 8'd0, operand_i.mantissa};
        up_in   = round_up(mode_eff, operand_i.sign, operand_i.mantissa[0], round_bits_i);
        sig_sum = {1'b0, sig_in} + {24'd0, up_in};
    end

    // S1 register: loads whenever it is empty or draining into S2
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid   <= 1'b0;
            s1_op      <= '0;
            s1_sum     <= '0;
            s1_mode    <= RM_RNE;
            s1_inexact <= 1'b0;
            s1_ovf_in  <= 1'b0;
            s1_unf_in  <= 1'b0;
            s1_nv      <= 1'b0;
        end else if (ready_o) begin
            s1_valid <= valid_i;
            if (valid_i) begin
                s1_op      <= operand_i;
                s1_sum     <= sig_sum;
                s1_mode    <= mode_eff;
                s1_inexact <= round_bits_i.guard | round_bits_i.round | round_bits_i.sticky;
                s1_ovf_in  <= overflow_i;
                s1_unf_in  <= underflow_i;
                s1_nv      <= invalid_i;
            end
        end
    end

    // S2: carry-out renormalisation, overflow saturation, special cases, flags
    always_comb begin
        s2_exp  = s1_op.exponent;
        s2_mant = s1_sum[22:0];
        if (s1_sum[24]) begin
            s2_exp  = s1_op.exponent + 8'd1;
            s2_mant = '0;
        end else if ((s1_op.exponent == 8'd0) && s1_sum[23]) begin
            // denormal rounded up into the smallest normal
            s2_exp = 8'd1;
        end
        s2_inf    = (s1_op.exponent == MAX_EXP);
        s2_ovf    = s1_ovf_in | (s2_exp == MAX_EXP);
        s2_nx     = s1_inexact | s2_ovf;
        s2_flags  = '0;
        s2_result = {s1_op.sign, s2_exp, s2_mant};
        if (s1_nv) begin
            s2_result   = CANONICAL_NAN;
            s2_flags.nv = 1'b1;
        end else if (s2_inf) begin
            s2_result = s1_op;
        end else begin
            s2_flags.of = s2_ovf;
            s2_flags.uf = s1_unf_in & s2_nx;
            s2_flags.nx = s2_nx;
            if (s2_ovf)
                s2_result = {s1_op.sign, sat_mag(s1_mode, s1_op.sign)};
        end
    end

    // Output register: holds its contents while the consumer stalls
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            flags_o  <= '0;
        end else if (s2_adv) begin
            valid_o <= s1_valid;
            if (s1_valid) begin
                result_o <= s2_result;
                flags_o  <= s2_flags;
            end
        end
    end

    // Sticky fflags; a clear coinciding with a handshake keeps only that result
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            acc_flags_o <= '0;
        else if (clear_flags_i)
            acc_flags_o <= out_hs ? flags_o : fflags_t'(5'b0);
        else if (out_hs)
            acc_flags_o <= fflags_t'(acc_flags_o | flags_o);
    end

endmodule

// File: tb/tb_floating_point_rounder.sv
// Self-checking bench for floating_point_rounder: directed corner cases plus
// randomized traffic with random backpressure, scored against a reference model.
module tb_floating_point_rounder;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_i;
    logic [2:0]  round_bits_i;
    logic        invalid_i, overflow_i, underflow_i;
    logic [2:0]  round_mode_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        clear_flags_i;
    logic [4:0]  acc_flags_o;

    int checks = 0;
    int errors = 0;

    logic [36:0] exp_q[$];
    logic [4:0]  exp_acc;
    logic        stalled;
    logic [36:0] prev_out;

    floating_point_rounder dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
        .operand_i(operand_i), .round_bits_i(round_bits_i),
        .invalid_i(invalid_i), .overflow_i(overflow_i), .underflow_i(underflow_i),
        .round_mode_i(round_mode_i), .valid_o(valid_o), .ready_i(ready_i),
        .result_o(result_o), .flags_o(flags_o),
        .clear_flags_i(clear_flags_i), .acc_flags_o(acc_flags_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, want);
        end
    endtask

    // Reference model: round the 31-bit magnitude as an integer, then saturate
    function automatic logic [36:0] model(input logic [31:0] op, input logic [2:0] grs,
                                          input logic nv, input logic of, input logic uf,
                                          input logic [2:0] mode);
        logic [2:0]  m;
        logic        up, sgn, inx, ovf, to_inf;
        logic [31:0] mag;
        logic [31:0] res;
`ifdef FPU_ROUND_MODES_EN
        m = (mode > 3'd4) ? 3'd0 : mode;
`else
        m = 3'd0;
`endif
        if (nv) return {32'h7FC00000, 5'b10000};
        if (op[30:23] == 8'hFF) return {op, 5'b00000};
        sgn = op[31];
        inx = |grs;
        case (m)
            3'd0:    up = grs[2] & (grs[1] | grs[0] | op[0]);
            3'd1:    up = 1'b0;
            3'd2:    up = sgn & inx;
            3'd3:    up = !sgn & inx;
            default: up = grs[2];
        endcase
        mag = {1'b0, op[30:0]} + {31'd0, up};
        ovf = of || (mag[30:23] == 8'hFF);
        if (ovf) begin
            to_inf = (m == 3'd0) || (m == 3'd4) || (m == 3'd2 && sgn) || (m == 3'd3 && !sgn);
            res = {sgn, to_inf ? 31'h7F800000 : 31'h7F7FFFFF};
        end else begin
            res = {sgn, mag[30:0]};
        end
        return {res, 1'b0, 1'b0, ovf, uf & (inx | ovf), inx | ovf};
    endfunction

    // Output monitor: scoreboard, hold-while-stalled, accumulated flags
    always @(negedge clk_i) begin
        logic        hs;
        logic [4:0]  nf;
        logic [36:0] e;
        if (!rst_n_i) begin
            exp_acc = '0;
            stalled = 1'b0;
        end else begin
            chk("acc_flags", {59'd0, acc_flags_o}, {59'd0, exp_acc});
            if (stalled && valid_o)
                chk("stall_hold", {27'd0, result_o, flags_o}, {27'd0, prev_out});
            hs = valid_o && ready_i;
            nf = '0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {63'd0, valid_o}, 64'd0);
                end else begin
                    e  = exp_q.pop_front();
                    nf = e[4:0];
                    chk("result_flags", {27'd0, result_o, flags_o}, {27'd0, e});
                end
            end
            if (clear_flags_i) exp_acc = hs ? nf : 5'd0;
            else if (hs)       exp_acc = exp_acc | nf;
            stalled  = valid_o && !ready_i;
            prev_out = {result_o, flags_o};
        end
    end

    // Present one operand at posedge+1 and hold it until accepted.
    // If use_k, the constant expectation is scored instead of the model.
    task automatic send(input logic [31:0] op, input logic [2:0] grs, input logic nv,
                        input logic of, input logic uf, input logic [2:0] mode,
                        input bit use_k, input logic [31:0] k_res, input logic [4:0] k_flg,
                        input bit rnd);
        int  waited;
        bit  done;
        operand_i = op; round_bits_i = grs; invalid_i = nv; overflow_i = of;
        underflow_i = uf; round_mode_i = mode; valid_i = 1'b1;
        if (rnd) begin
            ready_i = ($urandom_range(0, 3) != 0);
            clear_flags_i = ($urandom_range(0, 19) == 0);
        end
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk_i);
            if (ready_o) begin
                done = 1'b1;
            end else if (waited > 200) begin
                chk("accept_timeout", {63'd0, ready_o}, 64'd1);
                valid_i = 1'b0;
                return;
            end else begin
                waited++;
                @(posedge clk_i); #1;
                if (rnd) begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    clear_flags_i = ($urandom_range(0, 19) == 0);
                end
            end
        end
        exp_q.push_back(use_k ? {k_res, k_flg} : model(op, grs, nv, of, uf, mode));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        clear_flags_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        ready_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        chk("drain_left", {32'd0, exp_q.size()}, 64'd0);
    endtask

    initial begin
        logic [31:0] op;
        logic [31:0] bp_ops[4];
        int          idx;

        rst_n_i = 1'b0; valid_i = 1'b0; operand_i = '0; round_bits_i = '0;
        invalid_i = 1'b0; overflow_i = 1'b0; underflow_i = 1'b0; round_mode_i = '0;
        ready_i = 1'b1; clear_flags_i = 1'b0;
        #2;
        chk("rst_valid_o", {63'd0, valid_o}, 64'd0);
        chk("rst_ready_o", {63'd0, ready_o}, 64'd1);
        chk("rst_result_o", {32'd0, result_o}, 64'd0);
        chk("rst_flags_o", {59'd0, flags_o}, 64'd0);
        chk("rst_acc_flags", {59'd0, acc_flags_o}, 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        @(posedge clk_i); #1;

        // Latency: accepted at edge 1, visible after edge 2
        send(32'h3F800000, 3'b100, 0, 0, 0, 3'd0, 1, 32'h3F800000, 5'b00001, 0);
        @(negedge clk_i);
        chk("latency_not_early", {63'd0, valid_o}, 64'd0);
        @(negedge clk_i);
        chk("latency_2", {63'd0, valid_o}, 64'd1);
        @(posedge clk_i); #1;

        // Ties to even
        send(32'h3F800001, 3'b100, 0, 0, 0, 3'd0, 1, 32'h3F800002, 5'b00001, 0);
        // Carry into the exponent
`ifdef FPU_ROUND_MODES_EN
        send(32'h3F7FFFFF, 3'b110, 0, 0, 0, 3'd3, 1, 32'h3F800000, 5'b00001, 0);
        send(32'h3F7FFFFF, 3'b110, 0, 0, 0, 3'd1, 1, 32'h3F7FFFFF, 5'b00001, 0);
`else
        send(32'h3F7FFFFF, 3'b110, 0, 0, 0, 3'd3, 1, 32'h3F800000, 5'b00001, 0);
        send(32'h3F7FFFFF, 3'b110, 0, 0, 0, 3'd1, 1, 32'h3F800000, 5'b00001, 0);
`endif
        // Overflow saturation
        send(32'h7F7FFFFF, 3'b000, 0, 1, 0, 3'd0, 1, 32'h7F800000, 5'b00101, 0);
`ifdef FPU_ROUND_MODES_EN
        send(32'h7F7FFFFF, 3'b000, 0, 1, 0, 3'd1, 1, 32'h7F7FFFFF, 5'b00101, 0);
        send(32'hFF7FFFFF, 3'b000, 0, 1, 0, 3'd3, 1, 32'hFF7FFFFF, 5'b00101, 0);
`else
        send(32'h7F7FFFFF, 3'b000, 0, 1, 0, 3'd1, 1, 32'h7F800000, 5'b00101, 0);
        send(32'hFF7FFFFF, 3'b000, 0, 1, 0, 3'd3, 1, 32'hFF800000, 5'b00101, 0);
`endif
        // Rounding up into exponent 255 from the adder's max finite
        send(32'h7F7FFFFF, 3'b111, 0, 0, 0, 3'd0, 1, 32'h7F800000, 5'b00101, 0);
        // Infinity passes untouched, underflow only when inexact
        send(32'hFF800000, 3'b111, 0, 0, 1, 3'd0, 1, 32'hFF800000, 5'b00000, 0);
        send(32'h00000005, 3'b001, 0, 0, 1, 3'd0, 1, 32'h00000005, 5'b00011, 0);
        drain();

        // Invalid: canonical NaN and NV becomes sticky
        send(32'h7F800000, 3'b111, 1, 0, 0, 3'd0, 1, 32'h7FC00000, 5'b10000, 0);
        drain();
        chk("acc_gains_nv", {63'd0, acc_flags_o[4]}, 64'd1);

        // Clear coinciding with an NX-only handshake
        send(32'h3F800000, 3'b001, 0, 0, 0, 3'd0, 1, 32'h3F800000, 5'b00001, 0);
        @(posedge clk_i); #1;
        clear_flags_i = 1'b1;
        @(posedge clk_i); #1;
        clear_flags_i = 1'b0;
        chk("clear_with_hs", {59'd0, acc_flags_o}, 64'd1);

        // Backpressure: 4 back-to-back, consumer stalls 3 cycles
        bp_ops[0] = 32'h40000000; bp_ops[1] = 32'h40400001;
        bp_ops[2] = 32'hC0800003; bp_ops[3] = 32'h41200007;
        ready_i = 1'b0;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (c == 3) ready_i = 1'b1;
            if (idx < 4) begin
                operand_i = bp_ops[idx]; round_bits_i = 3'b101; invalid_i = 1'b0;
                overflow_i = 1'b0; underflow_i = 1'b0; round_mode_i = 3'd0; valid_i = 1'b1;
            end else begin
                valid_i = 1'b0;
            end
            @(negedge clk_i);
            if (c == 1) chk("bp_ready_second", {63'd0, ready_o}, 64'd1);
            if (c == 2) chk("bp_ready_low", {63'd0, ready_o}, 64'd0);
            if (valid_i && ready_o) begin
                exp_q.push_back(model(bp_ops[idx], 3'b101, 0, 0, 0, 3'd0));
                idx++;
            end
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
        chk("bp_all_accepted", {32'd0, idx}, 64'd4);
        drain();

        // Mid-operation reset drops in-flight results
        ready_i = 1'b0;
        send(32'h3F800000, 3'b000, 0, 0, 0, 3'd0, 0, 32'h0, 5'h0, 0);
        send(32'h40000000, 3'b000, 0, 0, 0, 3'd0, 0, 32'h0, 5'h0, 0);
        rst_n_i = 1'b0;
        exp_q.delete();
        #2;
        chk("midrst_valid_o", {63'd0, valid_o}, 64'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        ready_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            chk("post_rst_idle", {63'd0, valid_o}, 64'd0);
        end
        @(posedge clk_i); #1;

        // Randomized traffic with random backpressure and clears
        for (int n = 0; n < 400; n++) begin
            op = $urandom;
            case ($urandom_range(0, 5))
                0: op[30:23] = 8'hFE;
                1: op[30:23] = 8'hFF;
                2: op[30:0]  = 31'h7F7FFFFF;
                3: op[30:23] = 8'h00;
                4: op[22:0]  = 23'h7FFFFF;
                default: ;
            endcase
            send(op, 3'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 9) == 0),
                 1'($urandom), 3'($urandom), 0, 32'h0, 5'h0, 1);
            if ($urandom_range(0, 4) == 0) begin
                ready_i = ($urandom_range(0, 1) != 0);
                @(posedge clk_i); #1;
            end
        end
        drain();
        @(posedge clk_i); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/floating_point_rounder.md
FLOATING_POINT_ROUNDER -- requirements
Module: floating_point_rounder

Interface
REQ-001 SHALL have port: clk_i  input  1  clock; all flops rising-edge.
REQ-002 SHALL have port: rst_n_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: valid_i  input  1  upstream adder result valid.
REQ-004 SHALL have port: ready_o  output  1  rounder can accept this cycle.
REQ-005 SHALL have port: operand_i  input  32 (float32_t)  unrounded result from adder.
REQ-006 SHALL have port: round_bits_i  input  3 (round_bits_t)  guard/round/sticky.
REQ-007 SHALL have ports: invalid_i, overflow_i, underflow_i  input  1 each  adder exception flags.
REQ-008 SHALL have port: round_mode_i  input  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM.
REQ-009 SHALL have port: valid_o  output  1  rounded result valid.
REQ-010 SHALL have port: ready_i  input  1  downstream accepts.
REQ-011 SHALL have port: result_o  output  32 (float32_t)  rounded result.
REQ-012 SHALL have port: flags_o  output  5  per-result {NV,DZ,OF,UF,NX}.
REQ-013 SHALL have ports: clear_flags_i  input  1; acc_flags_o  output  5  sticky accumulated fflags.

Function
REQ-014 SHALL be a 2-stage elastic pipeline: S1 decides round-up and increments 24-bit significand; S2 handles carry-out, overflow saturation, flag generation.
REQ-015 SHALL advance a stage when it is empty or the next stage advances; output stage advances on ready_i.
REQ-016 SHALL drive ready_o = !S1_valid | S1_advance; latency 2 cycles with ready_i held high; one result per cycle throughput.
REQ-017 SHALL hold result_o/flags_o stable while valid_o & !ready_i; no result lost or duplicated; order preserved.
REQ-018 SHALL compute round-up: RNE G&(R|S|LSB); RTZ 0; RDN sign&(G|R|S); RUP !sign&(G|R|S); RMM G; codes 101-111 treated as RNE.
REQ-019 SHALL on significand carry-out set mantissa 0 and exponent+1; exponent reaching 255 SHALL be treated as overflow.
REQ-020 SHALL on overflow return: RNE/RMM +-inf; RTZ +-0x7F7FFFFF magnitude; RDN +max finite if positive, -inf if negative; RUP +inf if positive, -max finite if negative; set OF and NX.
REQ-021 SHALL set NX = G|R|S|overflow; UF = underflow_i & NX; DZ always 0.
REQ-022 SHALL on invalid_i output 0x7FC00000 with flags 10000, ignoring round bits.
REQ-023 SHALL pass operands with exponent 255 (inf) unrounded, flags 0.
REQ-024 SHALL OR flags_o into acc_flags_o on each valid_o & ready_i handshake.
REQ-025 SHALL on clear_flags_i clear acc_flags_o; simultaneous clear and handshake SHALL leave acc_flags_o = that result's flags_o.

Reset
REQ-026 SHALL on rst_n_i low clear both stage valids, valid_o=0, acc_flags_o=0, ready_o=1 (after reset), flags_o=0, result_o=0.
REQ-027 SHALL drop in-flight results on mid-operation reset; no output after deassertion until new valid_i.

Configuration
REQ-028 SHALL with FPU_ROUND_MODES_EN defined support all five modes per REQ-018/020.
REQ-029 SHALL without FPU_ROUND_MODES_EN ignore round_mode_i and always use RNE; port remains present.

Structure
REQ-030 SHALL use float32_t, round_bits_t, rounding_mode_t, fflags_t, CANONICAL_NAN, MAX_EXP from the floating_point_unit_pkg shared package; new rounding_mode_t and fflags_t are added there.
REQ-031 SHALL contain no sub-module; the round-up decision is a local function.

Verification
REQ-032 SHALL test tie-even: 0x3F800000, GRS=100, RNE -> 0x3F800000, flags 00001; 0x3F800001 same -> 0x3F800002, flags 00001.
REQ-033 SHALL test carry: 0x3F7FFFFF, GRS=110, RUP -> 0x3F800000, NX; RTZ -> 0x3F7FFFFF, NX.
REQ-034 SHALL test overflow: 0x7F7FFFFF, overflow_i=1, RNE -> 0x7F800000, flags 00101; RTZ -> 0x7F7FFFFF; 0xFF7FFFFF, RUP -> 0xFF7FFFFF.
REQ-035 SHALL test invalid: invalid_i=1, operand 0x7F800000 -> 0x7FC00000, flags 10000, acc_flags_o gains NV.
REQ-036 SHALL test backpressure: 4 back-to-back inputs, ready_i low 3 cycles -> ready_o low after 2 buffered, all 4 outputs delivered in order, values stable while stalled.
REQ-037 SHALL test clear_flags_i coincident with NX-only handshake after prior NV -> acc_flags_o = 00001.
